// File: rtl/fetch_pc_select_if.sv
// Fetch-stage PC select bus: hazard/pipeline inputs and selected-PC outputs.
// Optional mispredict counter signal present only when PC_PERF_CNT_EN is defined.
interface fetch_pc_select_if #(
  parameter int ADDR_W = 64
`ifdef PC_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic              F_stall;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [ADDR_W-1:0] M_valA;
  logic [3:0]        W_icode;
  logic [ADDR_W-1:0] W_valM;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [ADDR_W-1:0] F_predPC;
  logic              halted;
`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0]  mispredict_cnt;
`endif

  modport master (
    output F_stall, f_icode, f_valC, f_valP, M_icode, M_Cnd, M_valA, W_icode, W_valM,
    input  pc, pc_valid, F_predPC, halted
`ifdef PC_PERF_CNT_EN
    , input mispredict_cnt
`endif
  );

  modport slave (
    input  F_stall, f_icode, f_valC, f_valP, M_icode, M_Cnd, M_valA, W_icode, W_valM,
    output pc, pc_valid, F_predPC, halted
`ifdef PC_PERF_CNT_EN
    , output mispredict_cnt
`endif
  );
endinterface

// File: rtl/fetch_pc_select.sv
// Y86-64 fetch-stage PC register, next-PC predictor and redirect mux with ret/halt FSM.
// Define PC_PERF_CNT_EN to add the saturating mispredict counter.
module fetch_pc_select #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
`ifdef PC_PERF_CNT_EN
  , parameter int              CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  fetch_pc_select_if.slave bus
);

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pred_pc;
  logic              r_halted;

  logic              w_mis;
  logic              w_rr;
  logic              w_fetch;
  logic              w_load;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pred;
  state_t            w_next_state;

  // Redirect detection, PC mux, prediction and next-state decode
  always_comb begin
    w_mis = (bus.M_icode == IJXX) && !bus.M_Cnd;
    w_rr  = (bus.W_icode == IRET);
    if (w_mis) begin
      w_pc = bus.M_valA;
    end else if (w_rr) begin
      w_pc = bus.W_valM;
    end else begin
      w_pc = r_pred_pc;
    end
    if ((bus.f_icode == IJXX) || (bus.f_icode == ICALL)) begin
      w_pred = bus.f_valC;
    end else begin
      w_pred = bus.f_valP;
    end
    // A redirect always produces a real fetch, even out of RET_WAIT or HALT
    w_fetch = (r_state == ST_RUN) || w_mis || w_rr;
    w_load  = w_fetch && (!bus.F_stall || w_mis || w_rr);
    case (bus.f_icode)
      IRET:    w_next_state = ST_RET_WAIT;
      IHALT:   w_next_state = ST_HALT;
      default: w_next_state = ST_RUN;
    endcase
  end

  // F register and fetch FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RUN;
      r_pred_pc <= RESET_PC;
      r_halted  <= 1'b0;
    end else if (w_load) begin
      r_state   <= w_next_state;
      r_pred_pc <= w_pred;
      r_halted  <= (w_next_state == ST_HALT);
    end else begin
      r_state   <= r_state;
      r_pred_pc <= r_pred_pc;
      r_halted  <= r_halted;
    end
  end

  assign bus.pc       = w_pc;
  assign bus.pc_valid = w_fetch;
  assign bus.F_predPC = r_pred_pc;
  assign bus.halted   = r_halted;

`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] r_mis_cnt;

  // Saturating mispredict counter, independent of F_stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mis_cnt <= {CNT_W{1'b0}};
    end else if (w_mis && (r_mis_cnt != {CNT_W{1'b1}})) begin
      r_mis_cnt <= r_mis_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_mis_cnt <= r_mis_cnt;
    end
  end

  assign bus.mispredict_cnt = r_mis_cnt;
`endif

endmodule

// File: tb/tb_fetch_pc_select.sv
// Directed self-checking bench for fetch_pc_select (RESET_PC = 0x38).
// Counter checks are compiled in when PC_PERF_CNT_EN is defined.
module tb_fetch_pc_select;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  fetch_pc_select_if #(.ADDR_W(64)) bus ();

  fetch_pc_select #(.ADDR_W(64), .RESET_PC(64'h38)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.F_stall = 1'b0;
    bus.f_icode = 4'h2;
    bus.f_valC  = 64'h0;
    bus.f_valP  = 64'h0;
    bus.M_icode = 4'h1;
    bus.M_Cnd   = 1'b1;
    bus.M_valA  = 64'h0;
    bus.W_icode = 4'h1;
    bus.W_valM  = 64'h0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] valc, input logic [63:0] valp);
    bus.f_icode = ic;
    bus.f_valC  = valc;
    bus.f_valP  = valp;
  endtask

  task automatic test_reset();
    idle_inputs();
    fetch(4'h2, 64'h0, 64'h3A);
    #2 reset_n = 1'b0;
    #1;
    chk64("reset_pc", bus.pc, 64'h38);
    chk1("reset_pc_valid", bus.pc_valid, 1'b1);
    chk1("reset_halted", bus.halted, 1'b0);
    chk64("reset_predpc", bus.F_predPC, 64'h38);
`ifdef PC_PERF_CNT_EN
    chk64("reset_cnt", 64'(bus.mispredict_cnt), 64'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk64("after_reset_predpc", bus.F_predPC, 64'h3A);
  endtask

  task automatic test_predict();
    @(negedge clk);
    fetch(4'h8, 64'h100, 64'h49);
    #1 chk64("call_pc", bus.pc, 64'h3A);
    @(posedge clk); #1;
    chk64("call_predpc", bus.F_predPC, 64'h100);
    @(negedge clk);
    fetch(4'h7, 64'h140, 64'h10A);
    @(posedge clk); #1;
    chk64("jxx_predpc", bus.F_predPC, 64'h140);
    @(negedge clk);
    fetch(4'h3, 64'h777, 64'h14A);
    @(posedge clk); #1;
    chk64("seq_predpc", bus.F_predPC, 64'h14A);
  endtask

  task automatic test_mispredict_stall();
    @(negedge clk);
    bus.F_stall = 1'b1;
    bus.M_icode = 4'h7;
    bus.M_Cnd   = 1'b0;
    bus.M_valA  = 64'h50;
    fetch(4'h2, 64'h0, 64'h5A);
    #1;
    chk64("mis_pc", bus.pc, 64'h50);
    chk1("mis_pc_valid", bus.pc_valid, 1'b1);
`ifdef PC_PERF_CNT_EN
    chk64("mis_cnt_before", 64'(bus.mispredict_cnt), 64'h0);
`endif
    @(posedge clk); #1;
    chk64("mis_stall_predpc", bus.F_predPC, 64'h5A);
`ifdef PC_PERF_CNT_EN
    chk64("mis_cnt_after", 64'(bus.mispredict_cnt), 64'h1);
`endif
    // Taken jump in M is not a mispredict; stall must hold everything
    @(negedge clk);
    bus.M_Cnd = 1'b1;
    fetch(4'h2, 64'h0, 64'h77);
    #1 chk64("stall_pc", bus.pc, 64'h5A);
    @(posedge clk); #1;
    chk64("stall_hold_predpc", bus.F_predPC, 64'h5A);
`ifdef PC_PERF_CNT_EN
    chk64("taken_cnt_hold", 64'(bus.mispredict_cnt), 64'h1);
`endif
    @(negedge clk);
    idle_inputs();
    fetch(4'h2, 64'h0, 64'h5A);
  endtask

  task automatic test_ret();
    @(negedge clk);
    fetch(4'h9, 64'h0, 64'h5B);
    #1 chk1("ret_fetch_valid", bus.pc_valid, 1'b1);
    @(posedge clk); #1;
    chk64("ret_predpc", bus.F_predPC, 64'h5B);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fetch(4'h2, 64'h0, 64'h999);
      #1 chk1($sformatf("ret_bubble%0d", i), bus.pc_valid, 1'b0);
      @(posedge clk); #1;
      chk64($sformatf("ret_hold%0d", i), bus.F_predPC, 64'h5B);
    end
    @(negedge clk);
    bus.W_icode = 4'h9;
    bus.W_valM  = 64'h200;
    fetch(4'h2, 64'h0, 64'h202);
    #1;
    chk64("rr_pc", bus.pc, 64'h200);
    chk1("rr_pc_valid", bus.pc_valid, 1'b1);
    @(posedge clk); #1;
    chk64("rr_predpc", bus.F_predPC, 64'h202);
    @(negedge clk);
    bus.W_icode = 4'h1;
    #1 chk1("rr_back_to_run", bus.pc_valid, 1'b1);
  endtask

  task automatic test_halt();
    fetch(4'h0, 64'h0, 64'h203);
    @(posedge clk); #1;
    chk1("halt_halted", bus.halted, 1'b1);
    chk1("halt_pc_valid", bus.pc_valid, 1'b0);
    chk64("halt_predpc", bus.F_predPC, 64'h203);
    @(negedge clk);
    fetch(4'h2, 64'h0, 64'h999);
    @(posedge clk); #1;
    chk64("halt_frozen", bus.F_predPC, 64'h203);
    chk1("halt_stays", bus.halted, 1'b1);
    @(negedge clk);
    bus.M_icode = 4'h7;
    bus.M_Cnd   = 1'b0;
    bus.M_valA  = 64'h60;
    fetch(4'h2, 64'h0, 64'h62);
    #1;
    chk64("halt_mis_pc", bus.pc, 64'h60);
    chk1("halt_mis_valid", bus.pc_valid, 1'b1);
    @(posedge clk); #1;
    chk1("halt_exit", bus.halted, 1'b0);
    chk64("halt_exit_predpc", bus.F_predPC, 64'h62);
`ifdef PC_PERF_CNT_EN
    chk64("halt_mis_cnt", 64'(bus.mispredict_cnt), 64'h2);
`endif
  endtask

  task automatic test_mis_and_rr();
    @(negedge clk);
    bus.M_icode = 4'h7;
    bus.M_Cnd   = 1'b0;
    bus.M_valA  = 64'h70;
    bus.W_icode = 4'h9;
    bus.W_valM  = 64'h300;
    fetch(4'h2, 64'h0, 64'h72);
    #1 chk64("both_pc", bus.pc, 64'h70);
    @(posedge clk); #1;
    chk64("both_predpc", bus.F_predPC, 64'h72);
`ifdef PC_PERF_CNT_EN
    chk64("both_cnt", 64'(bus.mispredict_cnt), 64'h3);
`endif
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_ret_wait();
    fetch(4'h9, 64'h0, 64'h80);
    @(posedge clk); #1;
    @(negedge clk);
    fetch(4'h2, 64'h0, 64'h999);
    #1 chk1("rw_bubble", bus.pc_valid, 1'b0);
    reset_n = 1'b0;
    #1;
    chk1("rw_reset_valid", bus.pc_valid, 1'b1);
    chk64("rw_reset_pc", bus.pc, 64'h38);
    chk64("rw_reset_predpc", bus.F_predPC, 64'h38);
    chk1("rw_reset_halted", bus.halted, 1'b0);
`ifdef PC_PERF_CNT_EN
    chk64("rw_reset_cnt", 64'(bus.mispredict_cnt), 64'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_predict();
    test_mispredict_stall();
    test_ret();
    test_halt();
    test_mis_and_rr();
    test_reset_mid_ret_wait();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
